// File: rtl/ahb_slave_mux_decoder_pkg.sv
// Shared AHB-Lite types and constants for the slave-side mux/decoder and its
// built-in default slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  // NONSEQ and SEQ are the only transfer types that demand a real response.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == NONSEQ) || (trans == SEQ);
  endfunction

endpackage

// File: rtl/ahb_slave_mux_decoder_if.sv
// Bus bundle between the master side, the slave array and the mux/decoder.
// The slave modport is the mux/decoder's view; master is the surrounding fabric.
interface ahb_slave_mux_decoder_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]            HADDR;
  logic [1:0]                       HTRANS;
  logic                             HREADY;
  logic [DATA_WIDTH-1:0]            HRDATA;
  logic                             HRESP;
  logic [NUM_SLAVES-1:0]            s_HSEL;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_HRDATA;
  logic [NUM_SLAVES-1:0]            s_HRESP;
  logic [NUM_SLAVES-1:0]            s_HREADYOUT;

  modport slave (
    input  HADDR, HTRANS, s_HRDATA, s_HRESP, s_HREADYOUT,
    output HREADY, HRDATA, HRESP, s_HSEL
  );

  modport master (
    output HADDR, HTRANS, s_HRDATA, s_HRESP, s_HREADYOUT,
    input  HREADY, HRDATA, HRESP, s_HSEL
  );

endinterface

// File: rtl/ahb_slave_mux_decoder_default_slave.sv
// Default slave for unmapped space: two-cycle ERROR for active transfers,
// zero-wait OKAY otherwise. AHB_MUX_ERR_CNT_EN adds a saturating error counter.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hready,
  input  logic       miss,
  input  logic [1:0] htrans,
  output logic       ds_hready,
  output logic       ds_hresp
`ifdef AHB_MUX_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  ds_state_t state_r;
  ds_state_t state_s;
  logic      start_err_s;

  assign start_err_s = hready && miss && is_active(htrans);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= DS_OKAY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and Moore response outputs
  always_comb begin
    state_s   = state_r;
    ds_hready = 1'b1;
    ds_hresp  = HRESP_OKAY;
    case (state_r)
      DS_OKAY: begin
        if (start_err_s) begin
          state_s = DS_ERR1;
        end else begin
          state_s = DS_OKAY;
        end
      end
      DS_ERR1: begin
        ds_hready = 1'b0;
        ds_hresp  = HRESP_ERROR;
        state_s   = DS_ERR2;
      end
      DS_ERR2: begin
        ds_hresp = HRESP_ERROR;
        if (start_err_s) begin
          state_s = DS_ERR1;
        end else begin
          state_s = DS_OKAY;
        end
      end
      default: begin
        state_s = DS_OKAY;
      end
    endcase
  end

`ifdef AHB_MUX_ERR_CNT_EN
  // Count entries into DS_ERR1, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 16'h0000;
    end else if ((state_s == DS_ERR1) && (state_r != DS_ERR1) && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'h0001;
    end else begin
      err_count <= err_count;
    end
  end
`endif

endmodule

// File: rtl/ahb_slave_mux_decoder.sv
// AHB-Lite slave-side decoder and data-phase response mux with a built-in
// default slave. Optional AHB_MUX_ERR_CNT_EN exposes the default-slave error count.
module ahb_slave_mux_decoder
  import ahb_pkg::*;
#(
  parameter int                    NUM_SLAVES       = 4,
  parameter int                    ADDR_WIDTH       = 32,
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    SLAVE_ADDR_SPACE = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  ahb_slave_mux_decoder_if.slave  bus
`ifdef AHB_MUX_ERR_CNT_EN
  ,
  output logic [15:0]             err_count
`endif
);

  localparam int               SEL_W        = $clog2(NUM_SLAVES + 1);
  localparam logic [SEL_W-1:0] DSEL_DEFAULT = SEL_W'(NUM_SLAVES);

  logic [ADDR_WIDTH-1:0] off_s;
  logic [ADDR_WIDTH-1:0] idx_s;
  logic                  hit_s;
  logic [NUM_SLAVES-1:0] hsel_s;
  logic [SEL_W-1:0]      target_s;
  logic [SEL_W-1:0]      dsel_r;
  logic [DATA_WIDTH-1:0] hrdata_s;
  logic                  hresp_s;
  logic                  hready_s;
  logic                  slv_hresp_s;
  logic                  slv_hready_s;
  logic                  sel_i_s;
  logic                  ds_hready_s;
  logic                  ds_hresp_s;

  // Address-phase decode; addresses below BASE_ADDR wrap and must not alias a region
  always_comb begin
    off_s  = bus.HADDR - BASE_ADDR;
    idx_s  = off_s >> SLAVE_ADDR_SPACE;
    hit_s  = (bus.HADDR >= BASE_ADDR) && (idx_s < ADDR_WIDTH'(NUM_SLAVES));
    hsel_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hsel_s[i] = hit_s && (idx_s == ADDR_WIDTH'(i));
    end
    if (hit_s) begin
      target_s = idx_s[SEL_W-1:0];
    end else begin
      target_s = DSEL_DEFAULT;
    end
  end

  // Data-phase select: advances only when the current data phase completes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_r <= DSEL_DEFAULT;
    end else if (hready_s) begin
      dsel_r <= target_s;
    end else begin
      dsel_r <= dsel_r;
    end
  end

  // Response mux keyed on the registered data-phase select
  always_comb begin
    hrdata_s     = '0;
    slv_hresp_s  = 1'b0;
    slv_hready_s = 1'b0;
    sel_i_s      = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_i_s      = (dsel_r == SEL_W'(i));
      hrdata_s     = hrdata_s | ({DATA_WIDTH{sel_i_s}} & bus.s_HRDATA[i*DATA_WIDTH +: DATA_WIDTH]);
      slv_hresp_s  = slv_hresp_s | (sel_i_s & bus.s_HRESP[i]);
      slv_hready_s = slv_hready_s | (sel_i_s & bus.s_HREADYOUT[i]);
    end
    if (dsel_r < DSEL_DEFAULT) begin
      hresp_s  = slv_hresp_s;
      hready_s = slv_hready_s;
    end else begin
      hresp_s  = ds_hresp_s;
      hready_s = ds_hready_s;
    end
  end

  ahb_default_slave u_ds (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .hready    (hready_s),
    .miss      (!hit_s),
    .htrans    (bus.HTRANS),
    .ds_hready (ds_hready_s),
    .ds_hresp  (ds_hresp_s)
`ifdef AHB_MUX_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  assign bus.s_HSEL = hsel_s;
  assign bus.HRDATA = hrdata_s;
  assign bus.HRESP  = hresp_s;
  assign bus.HREADY = hready_s;

endmodule

// File: tb/tb_ahb_slave_mux_decoder.sv
// Scoreboard bench for ahb_slave_mux_decoder: data-phase expectations are queued
// when an address phase is accepted and checked when that data phase completes.
`timescale 1ns/1ps
module tb_ahb_slave_mux_decoder;
  import ahb_pkg::*;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic HCLK = 1'b0;
  logic HRESETn;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef AHB_MUX_ERR_CNT_EN
  logic [15:0] err_count;
  int          exp_err = 0;
`endif

  ahb_slave_mux_decoder_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  ahb_slave_mux_decoder #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SLAVE_ADDR_SPACE(10), .BASE_ADDR(32'h0000_0000)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
`ifdef AHB_MUX_ERR_CNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        resp;
    int          waits;
    logic        wait_resp;
    int          tgt;
  } exp_t;

  exp_t sb[$];
  int   waits_seen = 0;
  int   stall_left[NS];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(input int i);
    if (i == 1) return 32'hDEAD_BEEF;
    else return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic update_ready();
    for (int k = 0; k < NS; k++) bus.s_HREADYOUT[k] = (stall_left[k] == 0);
  endtask

  task automatic tick_stalls();
    for (int k = 0; k < NS; k++) if (stall_left[k] > 0) stall_left[k]--;
    update_ready();
  endtask

  // Called at posedge+1; samples at the following negedge.
  task automatic sample(output logic acc);
    exp_t e;
    #4;
`ifdef AHB_MUX_ERR_CNT_EN
    check_value("err_count", 32'(err_count), 32'(exp_err));
`endif
    if (bus.HREADY === 1'b1) begin
      acc = 1'b1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_value({e.tag, "_hrdata"}, bus.HRDATA, e.data);
        check_value({e.tag, "_hresp"}, 32'(bus.HRESP), 32'(e.resp));
        check_value({e.tag, "_waits"}, 32'(waits_seen), 32'(e.waits));
      end
      waits_seen = 0;
    end else begin
      acc = 1'b0;
      waits_seen++;
      if (sb.size() == 0) begin
        check_value("spurious_wait", 32'(bus.HREADY), 32'd1);
      end else begin
        check_value({sb[0].tag, "_wait_hresp"}, 32'(bus.HRESP), 32'(sb[0].wait_resp));
        check_value({sb[0].tag, "_dsel_hold"}, 32'(dut.dsel_r), 32'(sb[0].tgt));
      end
    end
  endtask

  task automatic issue(input string tag, input logic [31:0] addr, input logic [1:0] trans,
                       input logic [3:0] exp_hsel, input int tgt, input int waits);
    exp_t e;
    logic acc;
    int   n;
    bus.HADDR  = addr;
    bus.HTRANS = trans;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      sample(acc);
      check_value({tag, "_hsel"}, 32'(bus.s_HSEL), 32'(exp_hsel));
      @(posedge HCLK);
      #1;
      if (!acc) tick_stalls();
      n++;
    end
    if (!acc) check_value({tag, "_accept_timeout"}, 32'(acc), 32'd1);
    e.tag = tag;
    e.tgt = tgt;
    if (tgt < NS) begin
      e.data = slave_data(tgt); e.resp = 1'b0; e.waits = waits; e.wait_resp = 1'b0;
      stall_left[tgt] = waits;
      update_ready();
    end else if (trans == NONSEQ || trans == SEQ) begin
      e.data = 32'h0; e.resp = 1'b1; e.waits = 1; e.wait_resp = 1'b1;
`ifdef AHB_MUX_ERR_CNT_EN
      if (exp_err < 65535) exp_err++;
`endif
    end else begin
      e.data = 32'h0; e.resp = 1'b0; e.waits = 0; e.wait_resp = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic drain();
    logic acc;
    bus.HADDR  = 32'h0000_1000;
    bus.HTRANS = IDLE;
    for (int n = 0; n < 20 && sb.size() > 0; n++) begin
      sample(acc);
      @(posedge HCLK);
      #1;
      if (!acc) tick_stalls();
    end
    check_value("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    HRESETn         = 1'b0;
    bus.HADDR       = 32'h0000_0404;
    bus.HTRANS      = IDLE;
    bus.s_HRESP     = '0;
    for (int i = 0; i < NS; i++) begin
      stall_left[i] = 0;
      bus.s_HRDATA[i*DW +: DW] = slave_data(i);
    end
    update_ready();

    repeat (3) @(posedge HCLK);
    #5;
    check_value("reset_hready", 32'(bus.HREADY), 32'd1);
    check_value("reset_hresp", 32'(bus.HRESP), 32'd0);
    check_value("reset_hrdata", bus.HRDATA, 32'h0);
    check_value("reset_dsel", 32'(dut.dsel_r), 32'(NS));
    check_value("reset_hsel", 32'(bus.s_HSEL), 32'h2);
`ifdef AHB_MUX_ERR_CNT_EN
    check_value("reset_err_count", 32'(err_count), 32'd0);
`endif
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    issue("rd_s1",          32'h0000_0404, NONSEQ, 4'b0010, 1,  0);
    issue("b2b_s0",         32'h0000_0000, NONSEQ, 4'b0001, 0,  0);
    issue("b2b_s1",         32'h0000_0400, NONSEQ, 4'b0010, 1,  0);
    issue("stall_s2",       32'h0000_0800, NONSEQ, 4'b0100, 2,  3);
    issue("after_stall_s0", 32'h0000_0000, NONSEQ, 4'b0001, 0,  0);
    issue("last_hit_s3",    32'h0000_0FFF, NONSEQ, 4'b1000, 3,  0);
    issue("miss_end1",      32'h0000_1000, NONSEQ, 4'b0000, NS, 0);
    issue("idle_miss",      32'h0000_1000, IDLE,   4'b0000, NS, 0);
    issue("seq_miss",       32'h0000_2000, SEQ,    4'b0000, NS, 0);
    issue("b2b_miss",       32'h0000_2000, NONSEQ, 4'b0000, NS, 0);
    issue("busy_miss",      32'h0000_5000, BUSY,   4'b0000, NS, 0);
    issue("idle_s0",        32'h0000_0000, IDLE,   4'b0001, 0,  0);
    drain();

    issue("rst_miss",       32'h0000_3000, NONSEQ, 4'b0000, NS, 0);
    #1;
    check_value("err1_hready", 32'(bus.HREADY), 32'd0);
    check_value("err1_hresp", 32'(bus.HRESP), 32'd1);
    HRESETn = 1'b0;
    #1;
    check_value("midrst_hready", 32'(bus.HREADY), 32'd1);
    check_value("midrst_hresp", 32'(bus.HRESP), 32'd0);
    check_value("midrst_hrdata", bus.HRDATA, 32'h0);
`ifdef AHB_MUX_ERR_CNT_EN
    exp_err = 0;
    check_value("midrst_err_count", 32'(err_count), 32'd0);
`endif
    sb.delete();
    waits_seen = 0;
    bus.HTRANS = IDLE;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    check_value("postrst_fsm", 32'(dut.u_ds.state_r), 32'(DS_OKAY));
    check_value("postrst_hready", 32'(bus.HREADY), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/ahb_slave_mux_decoder.md
Name: ahb_slave_mux_decoder

Overview:
Parametrised AHB-Lite slave-side interconnect: decodes HADDR into one-hot slave selects for NUM_SLAVES memory slaves. Registers the data-phase select and muxes HRDATA/HRESP/HREADYOUT back to the master using that registered select. Contains a built-in default slave that returns a two-cycle ERROR for unmapped addresses. Sits between the master-facing interface and the array of slave instances, replacing the address-phase-indexed mux.

Parameters:
NUM_SLAVES, 4, number of attached slaves (1..16)
ADDR_WIDTH, 32, HADDR width
DATA_WIDTH, 32, HRDATA/HWDATA width
SLAVE_ADDR_SPACE, 10, log2 of bytes per slave region
BASE_ADDR, 32'h0, byte base of slave 0; region i = BASE_ADDR + i*2^SLAVE_ADDR_SPACE

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
HADDR  in  ADDR_WIDTH  master address (address phase)
HTRANS  in  2  master transfer type
HREADY  out  1  HREADY to master, also broadcast to all slaves as HREADY input
HRDATA  out  DATA_WIDTH  muxed read data to master
HRESP  out  1  muxed response to master (0 OKAY, 1 ERROR)
s_HSEL  out  NUM_SLAVES  one-hot slave select, address phase
s_HRDATA  in  NUM_SLAVES*DATA_WIDTH  packed slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
s_HRESP  in  NUM_SLAVES  slave responses
s_HREADYOUT  in  NUM_SLAVES  slave ready outputs

Behaviour:
- Decode (combinational): off = HADDR - BASE_ADDR; idx = off >> SLAVE_ADDR_SPACE. Hit when HADDR >= BASE_ADDR and idx < NUM_SLAVES. Hit: s_HSEL = 1 << idx. Miss: s_HSEL = 0 and the default slave is selected.
- s_HSEL is driven independent of HTRANS; slaves qualify selection with HTRANS and HREADY.
- Data-phase register dsel (idx, or DEFAULT code NUM_SLAVES) loads the decoded target only when HREADY==1. It holds while HREADY==0.
- Response mux uses dsel, never the live address:
  - dsel < NUM_SLAVES: HRDATA/HRESP/HREADY = s_HRDATA/s_HRESP/s_HREADYOUT of slave dsel.
  - dsel == DEFAULT: HRDATA = 0; HRESP and HREADY come from the default slave FSM.
- Default slave FSM, states DS_OKAY, DS_ERR1, DS_ERR2:
  - DS_OKAY: HREADY=1, HRESP=0. If HREADY && miss && HTRANS in {NONSEQ, SEQ}, go to DS_ERR1.
  - DS_ERR1: HREADY=0, HRESP=1. Always go to DS_ERR2.
  - DS_ERR2: HREADY=1, HRESP=1. On a new miss with NONSEQ/SEQ go to DS_ERR1, else go to DS_OKAY.
  - IDLE/BUSY to unmapped space: zero-wait OKAY.
- Reset (async, HRESETn low): dsel=DEFAULT, FSM=DS_OKAY. Outputs: HREADY=1, HRESP=0, HRDATA=0, s_HSEL follows decode.
- Latency: decode is 0 cycles. Response path is combinational from slave outputs; dsel adds 1 register stage, matching the AHB address/data pipeline.
- Wait states: a slave holding HREADYOUT=0 stalls the master. dsel and FSM are frozen, and the next address is not captured until HREADY=1.
- Back-to-back transfers to different slaves: dsel switches on the HREADY-high edge, with no bubble.
- Reset asserted mid-ERROR: FSM returns to DS_OKAY immediately and HREADY=1.
- Address exactly at region end + 1: miss (ERROR). Highest address of the last region: hit.

Optional Feature:
AHB_MUX_ERR_CNT_EN
- Defined: adds output port err_count (16 bits). It increments on each DS_OKAY/DS_ERR2 → DS_ERR1 transition and saturates at 16'hFFFF. It resets to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package ahb_pkg:
  - htrans_t enum (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - HRESP_OKAY/HRESP_ERROR constants.
  - ds_state_t enum.
- Sub-module ahb_default_slave: FSM plus optional error counter.
- The top instantiates the decoder logic, dsel register and mux.

Test Plan:
- Reset with HRESETn=0 for 3 cycles → HREADY=1, HRESP=0, HRDATA=0, dsel=DEFAULT.
- NONSEQ read at 0x0000_0404 (NUM_SLAVES=4), slave 1 returns 0xDEADBEEF with HREADYOUT=1 → s_HSEL=4'b0010 in address phase; HRDATA=0xDEADBEEF next cycle.
- Back-to-back NONSEQ to 0x000, 0x400, 0x800 → s_HSEL = 0001, 0010, 0100 on successive cycles; each data phase returns the correct slave's data, no bubbles.
- Slave 2 holds HREADYOUT=0 for 3 cycles while the master presents the next address for slave 0 → HREADY=0 for 3 cycles; dsel stays 2 until release.
- NONSEQ to 0x0000_1000 (unmapped) → s_HSEL=0; next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1; an IDLE to the same address gives zero-wait OKAY. With AHB_MUX_ERR_CNT_EN, err_count goes 0→1.
- Assert HRESETn low during DS_ERR1 → HREADY=1, HRESP=0 immediately; FSM is in DS_OKAY after release.
